// File: rtl/phy_rx_lane_deskew_if.sv
// Lane bus for the receive deskew stage: per-lane words going in from the
// descramblers and the column-aligned words coming back out.
interface phy_rx_lane_deskew_if #(
  parameter int MAX_NUM_LANES = 16,
  parameter int DATA_WIDTH    = 32
);

  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i;
  logic [MAX_NUM_LANES-1:0]            data_valid_i;
  logic [4*MAX_NUM_LANES-1:0]          data_k_i;
  logic [2*MAX_NUM_LANES-1:0]          sync_header_i;
  logic [MAX_NUM_LANES-1:0]            marker_i;

  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o;
  logic [MAX_NUM_LANES-1:0]            data_valid_o;
  logic [4*MAX_NUM_LANES-1:0]          data_k_o;
  logic [2*MAX_NUM_LANES-1:0]          sync_header_o;

  // Upstream side: drives lane words, observes aligned columns
  modport master (
    output data_i, data_valid_i, data_k_i, sync_header_i, marker_i,
    input  data_o, data_valid_o, data_k_o, sync_header_o
  );

  // Deskew block side
  modport slave (
    input  data_i, data_valid_i, data_k_i, sync_header_i, marker_i,
    output data_o, data_valid_o, data_k_o, sync_header_o
  );

endinterface

// File: rtl/phy_rx_lane_deskew.sv
// Multi-lane receive deskew. Each lane feeds a small circular FIFO; in SEARCH
// the lanes discard words until every active lane shows a marker at its head,
// then all active lanes pop in lock-step so columns leave aligned.
// Optional statistics (realign count, max skew at lock) are built when
// PHY_RX_DESKEW_STATS_EN is defined.
module phy_rx_lane_deskew #(
  parameter int MAX_NUM_LANES = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DESKEW_DEPTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [5:0]           num_active_lanes_i,
  phy_rx_lane_deskew_if.slave  lane_bus,
  output logic                 aligned_o,
  output logic                 deskew_error_o
`ifdef PHY_RX_DESKEW_STATS_EN
  ,
  output logic [15:0]                     realign_count_o,
  output logic [$clog2(DESKEW_DEPTH):0]   max_skew_o
`endif
);

  localparam int NL = MAX_NUM_LANES;
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(DESKEW_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DW + 7;

  typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED} state_t;

  state_t          state;
  state_t          next_state;
  logic [EW-1:0]   mem [NL][DESKEW_DEPTH];
  logic [PW-1:0]   wr_ptr [NL];
  logic [PW-1:0]   rd_ptr [NL];
  logic [EW-1:0]   head [NL];
  logic [5:0]      num_q;
  logic [PW-1:0]   hold_cnt;
  logic [PW-1:0]   cnt_next;

  logic [NL-1:0]   active;
  logic [NL-1:0]   empty;
  logic [NL-1:0]   full;
  logic [NL-1:0]   head_marker;
  logic [NL-1:0]   wr_req;
  logic [NL-1:0]   wr_en;
  logic [NL-1:0]   pop;
  logic            any_active;
  logic            all_marker;
  logic            any_marker;
  logic            all_ready;
  logic            lanes_changed;
  logic            overflow;
  logic            flush;
  logic            emit;
  logic            err;

  logic [NL*DW-1:0] col_data;
  logic [4*NL-1:0]  col_k;
  logic [2*NL-1:0]  col_sh;

  // Lane status, FSM decision, pop/write enables and the outgoing column.
  // The hold counter is seeded at 2 so that it counts from the marker's write
  // cycle; it then reaches DESKEW_DEPTH exactly when skew exceeds DEPTH-2.
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      active[l]      = l < int'(num_active_lanes_i);
      empty[l]       = wr_ptr[l] == rd_ptr[l];
      full[l]        = (wr_ptr[l][AW] != rd_ptr[l][AW]) &&
                       (wr_ptr[l][AW-1:0] == rd_ptr[l][AW-1:0]);
      head[l]        = mem[l][rd_ptr[l][AW-1:0]];
      head_marker[l] = !empty[l] && head[l][EW-1];
      wr_req[l]      = lane_bus.data_valid_i[l] && active[l] && (state != IDLE);
    end

    any_active    = |active;
    all_marker    = any_active && (&(head_marker | ~active));
    any_marker    = |(head_marker & active);
    all_ready     = any_active && (&(~empty | ~active));
    lanes_changed = num_active_lanes_i != num_q;

    next_state = state;
    flush      = 1'b0;
    pop        = '0;
    emit       = 1'b0;
    err        = 1'b0;
    cnt_next   = '0;

    case (state)
      IDLE: begin
        flush      = 1'b1;
        next_state = SEARCH;
      end
      SEARCH: begin
        if (all_marker) begin
          pop        = active;
          emit       = 1'b1;
          next_state = ALIGNED;
        end else begin
          pop = active & ~empty & ~head_marker;
          if (any_marker) begin
            cnt_next = (hold_cnt == '0) ? PW'(2) : hold_cnt + PW'(1);
            if (cnt_next == PW'(DESKEW_DEPTH)) begin
              err      = 1'b1;
              flush    = 1'b1;
              cnt_next = '0;
            end
          end
        end
      end
      ALIGNED: begin
        if (all_ready) begin
          if (any_marker && !all_marker) begin
            err        = 1'b1;
            flush      = 1'b1;
            next_state = SEARCH;
          end else begin
            pop  = active;
            emit = 1'b1;
          end
        end
      end
      default: begin
        flush      = 1'b1;
        next_state = IDLE;
      end
    endcase

    overflow = |(wr_req & full & ~pop);

    if (state != IDLE && lanes_changed) begin
      flush      = 1'b1;
      err        = 1'b0;
      emit       = 1'b0;
      next_state = SEARCH;
      cnt_next   = '0;
    end else if (state != IDLE && overflow) begin
      flush      = 1'b1;
      err        = 1'b1;
      emit       = 1'b0;
      next_state = SEARCH;
      cnt_next   = '0;
    end

    if (!en_i) begin
      flush      = 1'b1;
      err        = 1'b0;
      emit       = 1'b0;
      next_state = IDLE;
      cnt_next   = '0;
    end

    wr_en = wr_req & (~full | pop) & {NL{~flush}};

    col_data = '0;
    col_k    = '0;
    col_sh   = '0;
    for (int l = 0; l < NL; l++) begin
      if (active[l]) begin
        col_data[l*DW +: DW] = head[l][DW-1:0];
        col_k[l*4 +: 4]      = head[l][DW+3:DW];
        col_sh[l*2 +: 2]     = head[l][DW+5:DW+4];
      end
    end
  end

  // Lane storage: entry is {marker, sync_header, data_k, data}
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NL; l++) begin
      if (wr_en[l]) begin
        mem[l][wr_ptr[l][AW-1:0]] <= {lane_bus.marker_i[l],
                                      lane_bus.sync_header_i[l*2 +: 2],
                                      lane_bus.data_k_i[l*4 +: 4],
                                      lane_bus.data_i[l*DW +: DW]};
      end
    end
  end

  // FSM state, FIFO pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                  <= IDLE;
      hold_cnt               <= '0;
      num_q                  <= '0;
      aligned_o              <= 1'b0;
      deskew_error_o         <= 1'b0;
      lane_bus.data_o        <= '0;
      lane_bus.data_valid_o  <= '0;
      lane_bus.data_k_o      <= '0;
      lane_bus.sync_header_o <= '0;
      for (int l = 0; l < NL; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
      end
    end else begin
      state          <= next_state;
      hold_cnt       <= cnt_next;
      num_q          <= num_active_lanes_i;
      aligned_o      <= next_state == ALIGNED;
      deskew_error_o <= err;
      for (int l = 0; l < NL; l++) begin
        if (flush) begin
          wr_ptr[l] <= '0;
          rd_ptr[l] <= '0;
        end else begin
          if (wr_en[l]) wr_ptr[l] <= wr_ptr[l] + PW'(1);
          if (pop[l])   rd_ptr[l] <= rd_ptr[l] + PW'(1);
        end
      end
      if (emit) begin
        lane_bus.data_o        <= col_data;
        lane_bus.data_valid_o  <= active;
        lane_bus.data_k_o      <= col_k;
        lane_bus.sync_header_o <= col_sh;
      end else begin
        lane_bus.data_o        <= '0;
        lane_bus.data_valid_o  <= '0;
        lane_bus.data_k_o      <= '0;
        lane_bus.sync_header_o <= '0;
      end
    end
  end

`ifdef PHY_RX_DESKEW_STATS_EN
  logic [PW-1:0] occ_max;
  logic [PW-1:0] occ_min;
  logic [PW-1:0] occ_spread;
  logic [PW-1:0] occ;

  // Occupancy spread between active lanes, used when lock is acquired
  always_comb begin
    occ_max = '0;
    occ_min = PW'(DESKEW_DEPTH);
    occ     = '0;
    for (int l = 0; l < NL; l++) begin
      occ = wr_ptr[l] - rd_ptr[l];
      if (active[l]) begin
        if (occ > occ_max) occ_max = occ;
        if (occ < occ_min) occ_min = occ;
      end
    end
    occ_spread = any_active ? occ_max - occ_min : '0;
  end

  // Statistics survive en_i and realignment; only rst_i clears them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      realign_count_o <= '0;
      max_skew_o      <= '0;
    end else begin
      if (err && realign_count_o != 16'hFFFF) realign_count_o <= realign_count_o + 16'd1;
      if (state == SEARCH && next_state == ALIGNED && occ_spread > max_skew_o)
        max_skew_o <= occ_spread;
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_lane_deskew.sv
// Directed bench for phy_rx_lane_deskew: per-lane word streams with
// programmable skew, stalls and injected markers; aligned columns are
// compared against the stream model.
module tb_phy_rx_lane_deskew;

  localparam int NL = 16;
  localparam int DW = 32;
  localparam int DD = 8;
  localparam int CW = NL + 2*NL + 4*NL + NL*DW;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic [5:0] num_active_lanes_i;
  logic       aligned_o;
  logic       deskew_error_o;
`ifdef PHY_RX_DESKEW_STATS_EN
  logic [15:0]        realign_count_o;
  logic [$clog2(DD):0] max_skew_o;
`endif

  phy_rx_lane_deskew_if #(.MAX_NUM_LANES(NL), .DATA_WIDTH(DW)) lane_bus ();

  phy_rx_lane_deskew #(
    .MAX_NUM_LANES (NL),
    .DATA_WIDTH    (DW),
    .DESKEW_DEPTH  (DD)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .en_i               (en_i),
    .num_active_lanes_i (num_active_lanes_i),
    .lane_bus           (lane_bus),
    .aligned_o          (aligned_o),
`ifdef PHY_RX_DESKEW_STATS_EN
    .realign_count_o    (realign_count_o),
    .max_skew_o         (max_skew_o),
`endif
    .deskew_error_o     (deskew_error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int t;
  int kidx [NL];
  int skew [NL];
  logic [NL-1:0] stall;
  int inj_lane, inj_k;
  int exp_k, realign_k;
  bit chk_cols;
  int err_cnt, first_err_t, first_valid_t;
  bit aligned_seen, aligned_at_err;
  int valid_seen;
  logic [NL-1:0] vlog [64];
  logic          alog [64];

  task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] expColumn(input int k, input int n);
    logic [NL-1:0]    v;
    logic [2*NL-1:0]  sh;
    logic [4*NL-1:0]  kk;
    logic [NL*DW-1:0] d;
    v = '0; sh = '0; kk = '0; d = '0;
    for (int l = 0; l < n; l++) begin
      v[l]          = 1'b1;
      d[l*DW +: DW] = {8'(l), 24'(k)};
      kk[l*4 +: 4]  = 4'(l);
      sh[l*2 +: 2]  = 2'(k);
    end
    return {v, sh, kk, d};
  endfunction

  function automatic logic [CW-1:0] gotColumn();
    return {lane_bus.data_valid_o, lane_bus.sync_header_o, lane_bus.data_k_o, lane_bus.data_o};
  endfunction

  // Drive one cycle of every lane stream, clock it, then sample and score
  task automatic applyStimulus();
    logic [NL-1:0]    v;
    logic [NL-1:0]    m;
    logic [2*NL-1:0]  sh;
    logic [4*NL-1:0]  kk;
    logic [NL*DW-1:0] d;
    v = '0; m = '0; sh = '0; kk = '0; d = '0;
    for (int l = 0; l < NL; l++) begin
      if (t >= skew[l] && !stall[l]) begin
        v[l]          = 1'b1;
        d[l*DW +: DW] = {8'(l), 24'(kidx[l])};
        kk[l*4 +: 4]  = 4'(l);
        sh[l*2 +: 2]  = 2'(kidx[l]);
        m[l]          = ((kidx[l] % 16) == 2) || (l == inj_lane && kidx[l] == inj_k);
        kidx[l]++;
      end
    end
    lane_bus.data_i        = d;
    lane_bus.data_valid_i  = v;
    lane_bus.data_k_i      = kk;
    lane_bus.sync_header_i = sh;
    lane_bus.marker_i      = m;
    @(posedge clk_i);
    #1;
    if (t < 64) begin
      vlog[t] = lane_bus.data_valid_o;
      alog[t] = aligned_o;
    end
    if (aligned_o) aligned_seen = 1'b1;
    if (deskew_error_o) begin
      err_cnt++;
      if (first_err_t < 0) first_err_t = t;
      if (aligned_o) aligned_at_err = 1'b1;
      if (realign_k >= 0) exp_k = realign_k;
    end
    if (lane_bus.data_valid_o != '0) begin
      valid_seen++;
      if (first_valid_t < 0) first_valid_t = t;
      if (chk_cols) begin
        checkOutput($sformatf("col_k%0d", exp_k), gotColumn(), expColumn(exp_k, int'(num_active_lanes_i)));
        exp_k++;
      end
    end
    t++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic clearStats();
    err_cnt = 0; first_err_t = -1; first_valid_t = -1;
    aligned_seen = 1'b0; aligned_at_err = 1'b0; valid_seen = 0;
    for (int i = 0; i < 64; i++) begin
      vlog[i] = '0;
      alog[i] = 1'b0;
    end
  endtask

  // Reset, then one enabled idle cycle so stream cycle 0 starts in SEARCH
  task automatic doReset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    lane_bus.data_i = '0; lane_bus.data_valid_i = '0; lane_bus.data_k_i = '0;
    lane_bus.sync_header_i = '0; lane_bus.marker_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    en_i  = 1'b1;
    @(posedge clk_i);
    #1;
    t = 0;
    stall = '0;
    inj_lane = -1; inj_k = -1;
    realign_k = -1;
    for (int l = 0; l < NL; l++) kidx[l] = 0;
    clearStats();
  endtask

  initial begin
    rst_i = 1'b1;
    en_i = 1'b0;
    num_active_lanes_i = 6'd4;
    for (int l = 0; l < NL; l++) skew[l] = l % 4;

    // Reset state
    doReset();
    checkOutput("rst_col", gotColumn(), '0);
    checkOutput("rst_aligned", aligned_o, 1'b0);
    checkOutput("rst_err", deskew_error_o, 1'b0);

    // Test 1: 4 lanes, skew {0,1,2,3}
    $display("[TB] test 1: 4 lanes skew 0..3");
    num_active_lanes_i = 6'd4;
    for (int l = 0; l < NL; l++) skew[l] = l % 4;
    doReset();
    exp_k = 2; chk_cols = 1'b1;
    runCycles(20);
    checkOutput("t1_first_col_cycle", first_valid_t, 6);
    checkOutput("t1_aligned", aligned_o, 1'b1);
    checkOutput("t1_errors", err_cnt, 0);
    checkOutput("t1_next_k", exp_k, 16);
`ifdef PHY_RX_DESKEW_STATS_EN
    checkOutput("t1_max_skew", max_skew_o, 3);
    checkOutput("t1_realign_cnt", realign_count_o, 0);
`endif

    // Test 2: lane 3 skewed 7 words, never aligns
    $display("[TB] test 2: lane 3 skew 7");
    for (int l = 0; l < NL; l++) skew[l] = (l == 3) ? 7 : 0;
    doReset();
    chk_cols = 1'b0;
    runCycles(48);
    checkOutput("t2_first_err_cycle", first_err_t, 9);
    checkOutput("t2_err_count", err_cnt, 3);
    checkOutput("t2_never_aligned", aligned_seen, 1'b0);
    checkOutput("t2_no_columns", valid_seen, 0);
`ifdef PHY_RX_DESKEW_STATS_EN
    checkOutput("t2_realign_cnt", realign_count_o, 3);
`endif

    // Test 3: 8 lanes aligned, stray marker on lane 5
    $display("[TB] test 3: 8 lanes, stray marker lane 5");
    num_active_lanes_i = 6'd8;
    for (int l = 0; l < NL; l++) skew[l] = l % 4;
    doReset();
    inj_lane = 5; inj_k = 25;
    exp_k = 2; realign_k = 34; chk_cols = 1'b1;
    runCycles(60);
    checkOutput("t3_err_count", err_cnt, 1);
    checkOutput("t3_err_cycle", first_err_t, 29);
    checkOutput("t3_aligned_dropped", aligned_at_err, 1'b0);
    checkOutput("t3_realigned", aligned_o, 1'b1);
    checkOutput("t3_next_k", exp_k, 56);
`ifdef PHY_RX_DESKEW_STATS_EN
    checkOutput("t3_realign_cnt", realign_count_o, 1);
`endif

    // Test 4: lane 2 stalls for 3 cycles while aligned
    $display("[TB] test 4: lane 2 stall");
    num_active_lanes_i = 6'd4;
    for (int l = 0; l < NL; l++) skew[l] = 0;
    doReset();
    exp_k = 2; chk_cols = 1'b1;
    for (int c = 0; c < 25; c++) begin
      stall[2] = (c >= 12 && c <= 14);
      applyStimulus();
    end
    checkOutput("t4_valid_c12", vlog[12], 16'h000F);
    checkOutput("t4_valid_c13", vlog[13], 16'h0000);
    checkOutput("t4_valid_c14", vlog[14], 16'h0000);
    checkOutput("t4_valid_c15", vlog[15], 16'h0000);
    checkOutput("t4_valid_c16", vlog[16], 16'h000F);
    checkOutput("t4_errors", err_cnt, 0);
    checkOutput("t4_next_k", exp_k, 21);

    // Test 5: lane count 4 -> 2 while aligned
    $display("[TB] test 5: lane count change");
    num_active_lanes_i = 6'd4;
    doReset();
    exp_k = 2; chk_cols = 1'b1;
    runCycles(10);
    num_active_lanes_i = 6'd2;
    exp_k = 18;
    first_valid_t = -1;
    runCycles(20);
    checkOutput("t5_valid_change", vlog[10], 16'h0000);
    checkOutput("t5_aligned_change", alog[10], 1'b0);
    checkOutput("t5_first_col_cycle", first_valid_t, 19);
    checkOutput("t5_valid_2lanes", vlog[29], 16'h0003);
    checkOutput("t5_errors", err_cnt, 0);
    checkOutput("t5_next_k", exp_k, 29);

    // Test 6: en_i drop then rst_i mid-stream
    $display("[TB] test 6: en_i drop and rst_i mid-stream");
    num_active_lanes_i = 6'd4;
    doReset();
    exp_k = 2; chk_cols = 1'b1;
    runCycles(10);
    en_i = 1'b0;
    applyStimulus();
    checkOutput("t6_en_col", gotColumn(), '0);
    checkOutput("t6_en_aligned", aligned_o, 1'b0);
    checkOutput("t6_en_err", deskew_error_o, 1'b0);
    applyStimulus();
    en_i = 1'b1;
    exp_k = 18;
    first_valid_t = -1;
    runCycles(18);
    checkOutput("t6_reenable_col_cycle", first_valid_t, 19);
    checkOutput("t6_reenable_aligned", aligned_o, 1'b1);
    rst_i = 1'b1;
    chk_cols = 1'b0;
    applyStimulus();
    checkOutput("t6_rst_col", gotColumn(), '0);
    checkOutput("t6_rst_aligned", aligned_o, 1'b0);
    checkOutput("t6_rst_err", deskew_error_o, 1'b0);
`ifdef PHY_RX_DESKEW_STATS_EN
    checkOutput("t6_rst_realign_cnt", realign_count_o, 0);
    checkOutput("t6_rst_max_skew", max_skew_o, 0);
`endif
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
